serial_word_rx: RTL and testbench

//  Bit-serial receiver (deserializer). Reassembles WIDTH-bit words that an upstream shift chain emits one bit per strobe.

---
 rtl/serial_rx_pkg.sv | 8 +
 rtl/serial_bit_counter.sv | 23 ++
 rtl/serial_word_rx.sv | 125 ++++++++++++
 tb/tb_serial_word_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// serial_rx_pkg: receiver state encoding and shift/counter select codes
package serial_rx_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, FULL} rx_state_t;
    localparam logic [1:0] SEL_LOAD = 2'b00;
    localparam logic [1:0] SEL_SHL0 = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;
endpackage

// File: rtl/serial_bit_counter.sv
// serial_bit_counter: down-counter with load/decrement/hold that stops at zero
module serial_bit_counter
    import serial_rx_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_sel,
    input  logic [CNT_W-1:0] i_load,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;
    // any select other than LOAD or HOLD counts down, never past zero
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (i_sel == SEL_LOAD) r_cnt <= i_load;
        else if (i_sel != SEL_HOLD && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx: bit-serial deserializer with selectable shift edge and valid/ready output register
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic             DIR,
    input  logic             SIN,
    input  logic             SVALID,
    output logic [0:WIDTH-1] WORD,
    output logic             WVALID,
    input  logic             WREADY,
    output logic             BUSY,
    output logic [CNT_W-1:0] BITCNT,
    output logic             OVERRUN
);
    rx_state_t        r_state, w_state_nxt;
    logic [0:WIDTH-1] r_shift, w_shift_nxt, r_word;
    logic [1:0]       w_sh_sel, w_cnt_sel;
    logic [CNT_W-1:0] w_cnt_load;
    logic             w_zero, w_free, w_xfer, w_ovr_set, w_ovr_clr;
    logic             r_wvalid, r_overrun;

    assign w_free = !r_wvalid || WREADY;

    serial_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .i_sel  (w_cnt_sel),
        .i_load (w_cnt_load),
        .o_cnt  (BITCNT),
        .o_zero (w_zero)
    );

    // next state, shift/counter selects and the shift-to-output transfer decision
    always_comb begin
        w_state_nxt = r_state;
        w_sh_sel    = SEL_HOLD;
        w_cnt_sel   = SEL_HOLD;
        w_cnt_load  = '0;
        w_xfer      = 1'b0;
        w_ovr_set   = 1'b0;
        w_ovr_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = SHIFT;
                    w_sh_sel    = SEL_LOAD;
                    w_cnt_sel   = SEL_LOAD;
                    w_cnt_load  = CNT_W'(WIDTH);
                    w_ovr_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (ABORT) begin
                    w_state_nxt = IDLE;
                    w_cnt_sel   = SEL_LOAD;
                end else if (SVALID && !w_zero) begin
                    w_sh_sel  = DIR ? SEL_SHL0 : SEL_SHR;
                    w_cnt_sel = SEL_SHR;
                    if (BITCNT == CNT_W'(1)) begin
                        w_xfer      = w_free;
                        w_state_nxt = w_free ? IDLE : FULL;
                    end
                end
            end
            FULL: begin
                if (ABORT) begin
                    w_state_nxt = IDLE;
                    w_cnt_sel   = SEL_LOAD;
                end else begin
                    w_ovr_set   = SVALID;
                    w_xfer      = w_free;
                    w_state_nxt = w_free ? IDLE : FULL;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_shift_nxt = (w_sh_sel == SEL_LOAD) ? '0 :
                         (w_sh_sel == SEL_SHL0) ? {SIN, r_shift[0:WIDTH-2]} :
                         (w_sh_sel == SEL_SHR)  ? {r_shift[1:WIDTH-1], SIN} : r_shift;

    // state and shift register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // output register: refill on transfer, otherwise drop valid once accepted
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_word   <= '0;
            r_wvalid <= 1'b0;
        end else if (w_xfer) begin
            r_word   <= w_shift_nxt;
            r_wvalid <= 1'b1;
        end else if (WREADY) begin
            r_wvalid <= 1'b0;
        end
    end

    // sticky overrun flag, cleared when a new word is armed
    always_ff @(posedge CLK) begin
        if (RESET) r_overrun <= 1'b0;
        else if (w_ovr_clr) r_overrun <= 1'b0;
        else if (w_ovr_set) r_overrun <= 1'b1;
    end

    assign WORD    = r_word;
    assign WVALID  = r_wvalid;
    assign OVERRUN = r_overrun;
    assign BUSY    = (r_state != IDLE);
endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed scenarios plus random traffic against a word-level reference model
module tb_serial_word_rx;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort, dir, sin, svalid, wready;
    logic [0:W-1]  word;
    logic          wvalid, busy, overrun;
    logic [CW-1:0] bitcnt;
    int            total = 0;
    int            bad = 0;

    int m_st, m_left, m_sh, m_word;
    bit m_wv, m_ovr;

    always #5 clk = ~clk;

    serial_word_rx #(.WIDTH(W)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .START   (start),
        .ABORT   (abort),
        .DIR     (dir),
        .SIN     (sin),
        .SVALID  (svalid),
        .WORD    (word),
        .WVALID  (wvalid),
        .WREADY  (wready),
        .BUSY    (busy),
        .BITCNT  (bitcnt),
        .OVERRUN (overrun)
    );

    task automatic model_step();
        bit free, xfer;
        free = !m_wv || wready;
        xfer = 0;
        if (rst) begin
            m_st = 0; m_left = 0; m_sh = 0; m_word = 0; m_wv = 0; m_ovr = 0;
        end else begin
            if (m_st == 0) begin
                if (start) begin m_st = 1; m_left = W; m_ovr = 0; m_sh = 0; end
            end else if (abort) begin
                m_st = 0; m_left = 0;
            end else if (m_st == 1) begin
                if (svalid) begin
                    m_sh = dir ? ((m_sh >> 1) | (int'(sin) << (W - 1)))
                               : (((m_sh << 1) | int'(sin)) & ((1 << W) - 1));
                    m_left--;
                    if (m_left == 0) begin xfer = free; m_st = free ? 0 : 2; end
                end
            end else begin
                if (svalid) m_ovr = 1;
                if (free) begin xfer = 1; m_st = 0; end
            end
            if (xfer) begin m_word = m_sh; m_wv = 1; end
            else if (wready) m_wv = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] b, input logic d);
        start = 1; tick(); start = 0;
        dir = d; svalid = 1;
        for (int i = 0; i < W; i++) begin sin = b[3-i]; tick(); end
        svalid = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; svalid = 1; sin = 1; wready = 1;
        tick(); tick();
        total++;
        if ({word, wvalid, busy, bitcnt, overrun} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %b want 0", {word, wvalid, busy, bitcnt, overrun});
        end
        rst = 0; start = 0; svalid = 0; sin = 0; wready = 0;
    endtask

    task automatic test_basic();
        logic [3:0] b;
        b = 4'b1010;
        wready = 1; dir = 0; start = 1; tick(); start = 0;
        total++;
        if (bitcnt !== CW'(W)) begin bad++; $display("FAIL basic_cnt_start: got %0d want %0d", bitcnt, W); end
        for (int i = 0; i < W; i++) begin
            svalid = 1; sin = b[3-i]; tick();
            total++;
            if (bitcnt !== CW'(W - 1 - i)) begin bad++; $display("FAIL basic_cnt: got %0d want %0d", bitcnt, W - 1 - i); end
            total++;
            if (wvalid !== 1'(i == W - 1)) begin bad++; $display("FAIL basic_wvalid: got %b at bit %0d", wvalid, i); end
        end
        svalid = 0;
        total++;
        if (word !== 4'b1010) begin bad++; $display("FAIL basic_word: got %b want 1010", word); end
        tick();
        total++;
        if (wvalid !== 1'b0) begin bad++; $display("FAIL basic_wvalid_drop: got %b want 0", wvalid); end
    endtask

    task automatic test_dir_and_stall();
        wready = 1;
        send(4'b1100, 1);
        total++;
        if ({word, wvalid} !== {4'b0011, 1'b1}) begin bad++; $display("FAIL dir1_word: got %b/%b want 0011/1", word, wvalid); end
        send(4'b1010, 0);
        wready = 0;
        send(4'b0101, 0);
        tick();
        total++;
        if ({word, wvalid, busy} !== {4'b1010, 1'b1, 1'b1}) begin bad++; $display("FAIL stall_hold: got %b/%b/%b want 1010/1/1", word, wvalid, busy); end
        wready = 1; tick();
        total++;
        if ({word, wvalid, busy} !== {4'b0101, 1'b1, 1'b0}) begin bad++; $display("FAIL stall_release: got %b/%b/%b want 0101/1/0", word, wvalid, busy); end
        tick();
        total++;
        if (wvalid !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", wvalid); end
    endtask

    task automatic test_overrun();
        wready = 0;
        send(4'b0110, 0);
        send(4'b1001, 1);
        svalid = 1; sin = 1; tick(); tick(); svalid = 0;
        total++;
        if ({overrun, busy, word} !== {1'b1, 1'b1, 4'b0110}) begin bad++; $display("FAIL overrun_set: got %b/%b/%b want 1/1/0110", overrun, busy, word); end
        wready = 1; tick(); wready = 0;
        total++;
        if ({word, wvalid, overrun} !== {4'b1001, 1'b1, 1'b1}) begin bad++; $display("FAIL overrun_held_word: got %b/%b/%b want 1001/1/1", word, wvalid, overrun); end
        start = 1; tick(); start = 0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_abort();
        dir = 0; svalid = 1; sin = 1; tick(); tick(); svalid = 0;
        total++;
        if (bitcnt !== CW'(2)) begin bad++; $display("FAIL abort_partial_cnt: got %0d want 2", bitcnt); end
        abort = 1; start = 1; svalid = 1; tick(); abort = 0; start = 0; svalid = 0;
        total++;
        if ({bitcnt, busy, word, wvalid} !== {CW'(0), 1'b0, 4'b1001, 1'b1}) begin
            bad++; $display("FAIL abort_state: got %b want %b", {bitcnt, busy, word, wvalid}, {CW'(0), 1'b0, 4'b1001, 1'b1});
        end
        wready = 1;
        send(4'b0011, 0);
        total++;
        if ({word, wvalid} !== {4'b0011, 1'b1}) begin bad++; $display("FAIL abort_new_word: got %b/%b want 0011/1", word, wvalid); end
    endtask

    task automatic test_reset_mid();
        wready = 0;
        send(4'b1111, 0);
        start = 1; tick(); start = 0;
        svalid = 1; sin = 1; tick(); tick();
        rst = 1; wready = 1; tick(); tick();
        total++;
        if ({word, wvalid, busy, bitcnt, overrun} !== '0) begin bad++; $display("FAIL reset_mid: got %b want 0", {word, wvalid, busy, bitcnt, overrun}); end
        rst = 0; tick(); tick(); svalid = 0;
        total++;
        if ({word, wvalid, busy, bitcnt, overrun} !== '0) begin bad++; $display("FAIL idle_svalid: got %b want 0", {word, wvalid, busy, bitcnt, overrun}); end
    endtask

    task automatic test_back_to_back();
        wready = 0;
        send(4'b1100, 0);
        start = 1; tick(); start = 0;
        dir = 0; svalid = 1;
        sin = 0; tick(); sin = 1; tick(); sin = 1; tick();
        wready = 1; sin = 0; tick(); svalid = 0;
        total++;
        if ({word, wvalid, busy} !== {4'b0110, 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_refill: got %b/%b/%b want 0110/1/0", word, wvalid, busy); end
        tick();
        total++;
        if (wvalid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", wvalid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            start  = ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 24) == 0);
            dir    = 1'($urandom_range(0, 1));
            sin    = 1'($urandom_range(0, 1));
            svalid = ($urandom_range(0, 9) < 7);
            wready = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({word, wvalid, busy, bitcnt, overrun} !== {4'(m_word), m_wv, 1'(m_st != 0), CW'(m_left), m_ovr}) begin
                bad++;
                $display("FAIL random_cycle %0d: got %b want %b", i, {word, wvalid, busy, bitcnt, overrun},
                         {4'(m_word), m_wv, 1'(m_st != 0), CW'(m_left), m_ovr});
            end
        end
        rst = 0; start = 0; abort = 0; svalid = 0;
    endtask

    initial begin
        m_st = 0; m_left = 0; m_sh = 0; m_word = 0; m_wv = 0; m_ovr = 0;
        rst = 1; start = 0; abort = 0; dir = 0; sin = 0; svalid = 0; wready = 0;
        test_reset();
        test_basic();
        test_dir_and_stall();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
